// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and small helpers for the value-to-UART path.
package uart_pkg;

   localparam logic [7:0] ASCII_ZERO     = 8'h30;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam int         FRAME_BYTES    = 7;
   localparam int         BITS_PER_FRAME = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONVERT = 3'd1,
      LOAD    = 3'd2,
      SEND    = 3'd3,
      FINISH  = 3'd4
   } state_t;

   // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
   function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
      logic [19:0] adj;
      adj = bcd;
      for (int d = 0; d < 5; d++) begin
         if (bcd[d*4 +: 4] >= 4'd5) begin
            adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
         end
      end
      return adj;
   endfunction

   // Byte idx of the line "ddddd\r\n", most significant digit first.
   function automatic logic [7:0] frame_byte(input logic [19:0] bcd, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = ASCII_ZERO + {4'b0000, bcd[19:16]};
         3'd1:    b = ASCII_ZERO + {4'b0000, bcd[15:12]};
         3'd2:    b = ASCII_ZERO + {4'b0000, bcd[11:8]};
         3'd3:    b = ASCII_ZERO + {4'b0000, bcd[7:4]};
         3'd4:    b = ASCII_ZERO + {4'b0000, bcd[3:0]};
         3'd5:    b = ASCII_CR;
         default: b = ASCII_LF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, DIV clocks each.
// A load on the last clock of a stop bit chains the next frame with no idle gap.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int DIV = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       load,
   output logic       tx,
   output logic       bit_tick,
   output logic       byte_done
);

   localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
   localparam logic [3:0]     LAST_BIT = 4'(BITS_PER_FRAME - 1);

   logic          r_active;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_bit;
   logic [8:0]    r_shift;
   logic          r_tx;
   logic          w_tick;
   logic          w_last;

   assign w_tick    = r_active && (r_cnt == CNT_LAST);
   assign w_last    = w_tick && (r_bit == LAST_BIT);
   assign tx        = r_tx;
   assign bit_tick  = w_tick;
   assign byte_done = w_last;

   // Bit timing, shift register and line driver; load wins over the frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
         r_bit    <= 4'd0;
         r_shift  <= 9'd0;
         r_tx     <= 1'b1;
      end else if (load) begin
         r_active <= 1'b1;
         r_cnt    <= '0;
         r_bit    <= 4'd0;
         r_shift  <= {1'b1, data};
         r_tx     <= 1'b0;
      end else if (w_tick) begin
         r_cnt <= '0;
         if (r_bit == LAST_BIT) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
         end else begin
            r_bit   <= r_bit + 4'd1;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[8:1]};
         end
      end else if (r_active) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_value_tx.sv
// Captures a 16-bit value, converts it to five ASCII digits plus CR LF and
// sends the 7 bytes as one back-to-back 8N1 burst.
// Handshake: a request is taken on any clock edge where start=1 and busy=0;
// busy rises on that edge and stays high until the edge that raises done;
// requests while busy=1 are dropped, never queued.
module uart_value_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in,
   input  logic        start,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic        bit_tick
);

   localparam int         DIV        = CLK_FREQ / BAUD;
   localparam logic [2:0] LAST_INDEX = 3'(FRAME_BYTES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_value;
   logic [19:0] r_bcd;
   logic [3:0]  r_cnt;
   logic [2:0]  r_index;
   logic        r_first;

   logic        w_accept;
   logic [19:0] w_adj;
   logic [2:0]  w_sel;
   logic [7:0]  w_data;
   logic        w_load;
   logic        w_byte_done;

   assign w_accept = start && ((r_state == IDLE) || (r_state == FINISH));
   assign w_adj    = dabble_adjust(r_bcd);
   assign w_sel    = r_first ? 3'd0 : (r_index + 3'd1);
   assign w_data   = frame_byte(r_bcd, w_sel);
   assign w_load   = (r_state == SEND) &&
                     (r_first || (w_byte_done && (r_index != LAST_INDEX)));
   assign busy     = (r_state == CONVERT) || (r_state == LOAD) || (r_state == SEND);
   assign done     = (r_state == FINISH);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = CONVERT;
         CONVERT: if (r_cnt == 4'd15) w_next = LOAD;
         LOAD:    w_next = SEND;
         SEND:    if (w_byte_done && (r_index == LAST_INDEX)) w_next = FINISH;
         FINISH:  w_next = w_accept ? CONVERT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Value capture, double-dabble conversion and byte sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= 16'd0;
         r_bcd   <= 20'd0;
         r_cnt   <= 4'd0;
         r_index <= 3'd0;
         r_first <= 1'b0;
      end else begin
         case (r_state)
            IDLE, FINISH: begin
               if (w_accept) begin
                  r_value <= in;
                  r_bcd   <= 20'd0;
                  r_cnt   <= 4'd0;
               end
            end
            CONVERT: begin
               r_bcd   <= {w_adj[18:0], r_value[15]};
               r_value <= {r_value[14:0], 1'b0};
               r_cnt   <= r_cnt + 4'd1;
            end
            LOAD: begin
               r_index <= 3'd0;
               r_first <= 1'b1;
            end
            SEND: begin
               if (r_first) begin
                  r_first <= 1'b0;
               end else if (w_byte_done && (r_index != LAST_INDEX)) begin
                  r_index <= r_index + 3'd1;
               end
            end
            default: begin
               r_first <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .DIV (DIV)
   ) u_tx_byte (
      .clk       (clk),
      .rst       (rst),
      .data      (w_data),
      .load      (w_load),
      .tx        (tx),
      .bit_tick  (bit_tick),
      .byte_done (w_byte_done)
   );

endmodule

// File: tb/tb_uart_value_tx.sv
// Bench for uart_value_tx: small-divider instance for function, default instance for timing.
module tb_uart_value_tx;

   localparam int TB_DIV    = 10;
   localparam int LAT       = 18;
   localparam int FRAME_CYC = LAT + 70 * TB_DIV;
   localparam int DEF_DIV   = 100_000_000 / 115200;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic        start;
   logic        tx, busy, done, bit_tick;
   logic [15:0] in2;
   logic        start2;
   logic        tx2, busy2, done2, bit_tick2;

   int          n_pass;
   int          n_checks;
   logic [7:0]  exp_bytes [0:6];
   logic [7:0]  exp_q[$];

   uart_value_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk(clk), .rst(rst), .in(in), .start(start),
      .tx(tx), .busy(busy), .done(done), .bit_tick(bit_tick)
   );

   uart_value_tx dut2 (
      .clk(clk), .rst(rst), .in(in2), .start(start2),
      .tx(tx2), .busy(busy2), .done(done2), .bit_tick(bit_tick2)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Reference: the decimal text of v followed by CR LF.
   task automatic set_expected(input int v);
      int dig [0:4];
      dig[0] = (v / 10000) % 10;
      dig[1] = (v / 1000) % 10;
      dig[2] = (v / 100) % 10;
      dig[3] = (v / 10) % 10;
      dig[4] = v % 10;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         exp_bytes[i] = 8'(8'h30 + dig[i]);
      end
      exp_bytes[5] = 8'h0D;
      exp_bytes[6] = 8'h0A;
      for (int i = 0; i < 7; i++) exp_q.push_back(exp_bytes[i]);
   endtask

   // Ideal line level rel clocks after the first start-bit fall.
   function automatic logic exp_line(input int rel, input int div);
      int b;
      int p;
      if (rel < 0 || rel >= 70 * div) return 1'b1;
      b = rel / div;
      p = b % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return exp_bytes[b / 10][p - 1];
   endfunction

   // One full request on the small instance; optional extra start pulses at inj1/inj2.
   task automatic frame_test(input int v, input int inj1, input int inj2, input bit hold);
      int   tx_bad, busy_bad, tick_bad, tick_cnt, done_cnt, done_at, first_fall, s;
      logic trace [0:FRAME_CYC];
      logic exp_tick;
      logic [7:0] rx;
      logic [7:0] want;
      tx_bad = 0; busy_bad = 0; tick_bad = 0; tick_cnt = 0;
      done_cnt = 0; done_at = -1; first_fall = -1;
      set_expected(v);
      in    = 16'(v);
      start = 1'b1;
      @(negedge clk);
      trace[0] = tx;
      in    = 16'($urandom_range(0, 65535));
      start = hold;
      for (int t = 1; t <= FRAME_CYC; t++) begin
         @(negedge clk);
         trace[t] = tx;
         if (tx !== exp_line(t - LAT, TB_DIV)) tx_bad++;
         if (busy !== (t < FRAME_CYC)) busy_bad++;
         exp_tick = (t >= LAT) && (t < FRAME_CYC) && (((t - LAT) % TB_DIV) == TB_DIV - 1);
         if (bit_tick !== exp_tick) tick_bad++;
         if (bit_tick === 1'b1) tick_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = t;
         end
         if (first_fall < 0 && tx === 1'b0) first_fall = t;
         start = hold || (t == inj1) || (t == inj2);
         if (t == inj1 || t == inj2) in = 16'd1234;
      end
      check($sformatf("latency v=%0d", v), first_fall, LAT);
      check($sformatf("waveform v=%0d", v), tx_bad, 0);
      check($sformatf("busy v=%0d", v), busy_bad, 0);
      check($sformatf("tick_pos v=%0d", v), tick_bad, 0);
      check($sformatf("tick_cnt v=%0d", v), tick_cnt, 70);
      check($sformatf("done_cnt v=%0d", v), done_cnt, 1);
      check($sformatf("done_at v=%0d", v), done_at, FRAME_CYC);
      for (int j = 0; j < 7; j++) begin
         s = LAT + j * 10 * TB_DIV;
         for (int k = 0; k < 8; k++) rx[k] = trace[s + (k + 1) * TB_DIV + TB_DIV / 2];
         want = exp_q.pop_front();
         check($sformatf("byte%0d v=%0d", j, v), rx, want);
      end
   endtask

   initial begin
      int bad, tx_bad2, tick_cnt2, done_cnt2, done_at2, fall2;
      n_pass = 0; n_checks = 0;
      rst = 1'b1; start = 1'b0; in = 16'd0; start2 = 1'b0; in2 = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tick", bit_tick, 0);
      check("rst_tx2", tx2, 1);
      rst = 1'b0;
      @(negedge clk);

      frame_test(89, -1, -1, 1'b0);
      repeat (3) @(negedge clk);
      frame_test(65535, -1, -1, 1'b0);
      repeat (3) @(negedge clk);
      frame_test(0, -1, -1, 1'b0);
      repeat (3) @(negedge clk);
      frame_test(int'($urandom_range(0, 65535)), 5, 300, 1'b0);
      repeat (3) @(negedge clk);

      // Reset in the middle of byte 3.
      set_expected(89);
      in = 16'd89; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 1; t <= 333; t++) @(negedge clk);
      check("pre_rst_line", tx, exp_line(333 - LAT, TB_DIV));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      rst = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("post_rst_quiet", bad, 0);
      frame_test(7, -1, -1, 1'b0);
      repeat (3) @(negedge clk);

      // start held high: frames chained through FINISH.
      frame_test(int'($urandom_range(0, 65535)), -1, -1, 1'b1);
      frame_test(int'($urandom_range(0, 65535)), -1, -1, 1'b1);
      frame_test(int'($urandom_range(0, 65535)), -1, -1, 1'b0);
      repeat (3) @(negedge clk);
      frame_test(int'($urandom_range(0, 65535)), -1, -1, 1'b0);
      repeat (3) @(negedge clk);

      // Default divider: full frame timing on the second instance.
      set_expected(89);
      tx_bad2 = 0; tick_cnt2 = 0; done_cnt2 = 0; done_at2 = -1; fall2 = -1;
      in2 = 16'd89; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int t = 1; t <= LAT + 70 * DEF_DIV + 2; t++) begin
         @(negedge clk);
         if (tx2 !== exp_line(t - LAT, DEF_DIV)) tx_bad2++;
         if (bit_tick2 === 1'b1) tick_cnt2++;
         if (done2 === 1'b1) begin
            done_cnt2++;
            done_at2 = t;
         end
         if (fall2 < 0 && tx2 === 1'b0) fall2 = t;
      end
      check("def_latency", fall2, LAT);
      check("def_waveform", tx_bad2, 0);
      check("def_tick_cnt", tick_cnt2, 70);
      check("def_done_cnt", done_cnt2, 1);
      check("def_span", done_at2 - fall2, 60760);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
